ps2_mouse_seq: RTL

//  Host-side sequencer for a PS/2 mouse on top of the byte-level PS/2 transceiver (PS2_CLK/PS2_DAT pins).

---
 rtl/ps2_mouse_pkg.sv | 47 ++++
 rtl/ps2_pkt_asm.sv | 114 +++++++++++
 rtl/ps2_mouse_seq.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_pkg.sv
// Shared constants for the PS/2 mouse host sequencer: command/response bytes,
// init FSM state encodings and a microsecond-to-cycle helper.
package ps2_mouse_pkg;

  // Host-to-device commands
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_SETRATE = 8'hF3;
  localparam logic [7:0] CMD_GETID   = 8'hF2;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  // Sample-rate arguments forming the IntelliMouse wheel knock (200, 100, 80)
  localparam logic [7:0] RATE_200 = 8'hC8;
  localparam logic [7:0] RATE_100 = 8'h64;
  localparam logic [7:0] RATE_80  = 8'h50;

  // Device-to-host responses
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
  localparam logic [7:0] RSP_BAT_ID   = 8'h00;
  localparam logic [7:0] ID_WHEEL     = 8'h03;

  // Byte0 of every stream packet has this bit set; used to resync
  localparam int unsigned SYNC_BIT   = 3;
  localparam int unsigned MAX_RESEND = 2;

  // Init FSM states
  localparam logic [3:0] S_IDLE_RST    = 4'd0;
  localparam logic [3:0] S_SEND        = 4'd1;
  localparam logic [3:0] S_WAIT_TX     = 4'd2;
  localparam logic [3:0] S_WAIT_ACK    = 4'd3;
  localparam logic [3:0] S_WAIT_BAT    = 4'd4;
  localparam logic [3:0] S_WAIT_BAT_ID = 4'd5;
  localparam logic [3:0] S_WAIT_ID     = 4'd6;
  localparam logic [3:0] S_STREAM      = 4'd7;
  localparam logic [3:0] S_ERROR       = 4'd8;

  // Timeout in clock cycles, never less than one
  function automatic longint unsigned us_to_cyc(input longint unsigned hz,
                                                input longint unsigned us);
    longint unsigned c;
    c = (hz * us) / 64'd1_000_000;
    return (c == 64'd0) ? 64'd1 : c;
  endfunction

endpackage

// File: rtl/ps2_pkt_asm.sv
// Stream packet assembler: collects 3- or 4-byte mouse packets, resyncs on
// byte0 bit3, drops partial packets on gap timeout or rx error, decodes fields.
module ps2_pkt_asm
  import ps2_mouse_pkg::*;
#(
  parameter int unsigned GAP_CYC = 100_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic       wheel_mode,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic       pkt_valid,
  output logic [2:0] btn,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic [3:0] dz,
  output logic [1:0] ovf
);

  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

  logic [1:0]       idx_q, idx_d;
  logic [7:0]       b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic [2:0]       btn_q, btn_d;
  logic [8:0]       dx_q, dx_d, dy_q, dy_d;
  logic [3:0]       dz_q, dz_d;
  logic [1:0]       ovf_q, ovf_d;
  logic             last_c;
  logic [7:0]       ybyte_c;

  // Byte collection, resync, gap handling and field decode
  always_comb begin
    idx_d       = idx_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    gap_d       = (gap_q != '0) ? gap_q - GAP_W'(1) : '0;
    pkt_valid_d = 1'b0;
    btn_d       = btn_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    last_c      = wheel_mode ? (idx_q == 2'd3) : (idx_q == 2'd2);
    // In 4-byte mode the Y byte was stored at index 2; in 3-byte mode it is the current byte
    ybyte_c     = wheel_mode ? b2_q : rx_data;

    if (!en || rx_err || ((idx_q != 2'd0) && (gap_q == '0))) begin
      idx_d = 2'd0;
    end else if (rx_valid) begin
      gap_d = GAP_W'(GAP_CYC);
      if (idx_q == 2'd0) begin
        if (rx_data[SYNC_BIT]) begin
          b0_d  = rx_data;
          idx_d = 2'd1;
        end
      end else if (last_c) begin
        pkt_valid_d = 1'b1;
        btn_d       = b0_q[2:0];
        dx_d        = {b0_q[4], b1_q};
        dy_d        = {b0_q[5], ybyte_c};
        dz_d        = wheel_mode ? rx_data[3:0] : 4'h0;
        ovf_d       = {b0_q[7], b0_q[6]};
        idx_d       = 2'd0;
      end else begin
        if (idx_q == 2'd1) b1_d = rx_data;
        else               b2_d = rx_data;
        idx_d = idx_q + 2'd1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_q       <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      gap_q       <= '0;
      pkt_valid_q <= 1'b0;
      btn_q       <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      dz_q        <= '0;
      ovf_q       <= '0;
    end else begin
      idx_q       <= idx_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      gap_q       <= gap_d;
      pkt_valid_q <= pkt_valid_d;
      btn_q       <= btn_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign pkt_valid = pkt_valid_q;
  assign btn       = btn_q;
  assign dx        = dx_q;
  assign dy        = dy_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

endmodule

// File: rtl/ps2_mouse_seq.sv
// PS/2 mouse host sequencer: power-on init FSM with command ROM, resend and
// retry handling, then hands the byte stream to ps2_pkt_asm.
// PS2_MOUSE_WHEEL_EN: when defined, adds the IntelliMouse knock (F3 C8/64/50)
// and ID read; otherwise only FF, BAT, F4 are run and packets are 3 bytes.
module ps2_mouse_seq
  import ps2_mouse_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned ACK_TO_US = 25_000,
  parameter int unsigned BAT_TO_US = 1_000_000,
  parameter int unsigned GAP_TO_US = 2_000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       reinit,
  output logic [7:0] tx_data,
  output logic       tx_req,
  input  logic       tx_busy,
  input  logic       tx_err,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic       init_done,
  output logic       init_err,
  output logic       wheel_mode,
  output logic       pkt_valid,
  output logic [2:0] btn,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic [3:0] dz,
  output logic [1:0] ovf
);

  localparam longint unsigned ACK_CYC = us_to_cyc(64'(CLK_HZ), 64'(ACK_TO_US));
  localparam longint unsigned BAT_CYC = us_to_cyc(64'(CLK_HZ), 64'(BAT_TO_US));
  localparam int unsigned     GAP_CYC = 32'(us_to_cyc(64'(CLK_HZ), 64'(GAP_TO_US)));
  localparam int unsigned     TMR_W   = $clog2(BAT_CYC + 64'd1);
  localparam int unsigned     RTY_W   = $clog2(MAX_RETRY + 1);
  localparam logic [TMR_W-1:0] ACK_LD = TMR_W'(ACK_CYC);
  localparam logic [TMR_W-1:0] BAT_LD = TMR_W'(BAT_CYC);

`ifdef PS2_MOUSE_WHEEL_EN
  localparam logic [3:0] STEP_GETID = 4'd7;
  localparam logic [3:0] STEP_LAST  = 4'd8;
`else
  localparam logic [3:0] STEP_GETID = 4'd15;
  localparam logic [3:0] STEP_LAST  = 4'd1;
`endif

  // Command ROM: init step index -> command byte
  function automatic logic [7:0] step_byte(input logic [3:0] s);
    logic [7:0] b;
`ifdef PS2_MOUSE_WHEEL_EN
    case (s)
      4'd0:    b = CMD_RESET;
      4'd1:    b = CMD_SETRATE;
      4'd2:    b = RATE_200;
      4'd3:    b = CMD_SETRATE;
      4'd4:    b = RATE_100;
      4'd5:    b = CMD_SETRATE;
      4'd6:    b = RATE_80;
      4'd7:    b = CMD_GETID;
      default: b = CMD_ENABLE;
    endcase
`else
    b = (s == 4'd0) ? CMD_RESET : CMD_ENABLE;
`endif
    return b;
  endfunction

  logic [3:0]       state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [1:0]       resend_q, resend_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             busy_seen_q, busy_seen_d;
  logic             tx_req_q, tx_req_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             init_done_q, init_err_q, init_err_d;
  logic             wheel_q, wheel_d;
  logic             accept, fail, advance;
  logic [31:0]      retry_inc;

  // Init FSM next-state, timer and output logic
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    resend_d    = resend_q;
    retry_d     = retry_q;
    timer_d     = (timer_q != '0) ? timer_q - TMR_W'(1) : '0;
    busy_seen_d = busy_seen_q;
    tx_req_d    = 1'b0;
    tx_data_d   = tx_data_q;
    init_err_d  = init_err_q;
    wheel_d     = wheel_q;
    accept      = 1'b0;
    fail        = 1'b0;
    advance     = 1'b0;
    retry_inc   = 32'(retry_q) + 32'd1;

    case (state_q)
      S_IDLE_RST: state_d = S_SEND;
      S_SEND: begin
        if (!tx_busy) begin
          tx_req_d    = 1'b1;
          tx_data_d   = step_byte(step_q);
          busy_seen_d = 1'b0;
          state_d     = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (tx_err || (timer_q == '0)) fail = 1'b1;
        else if (tx_busy)              busy_seen_d = 1'b1;
        else if (busy_seen_q)          state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (rx_err || (timer_q == '0)) begin
          fail = 1'b1;
        end else if (rx_valid) begin
          accept = 1'b1;
          if (rx_data == RSP_ACK) begin
            if (step_q == 4'd0)            state_d = S_WAIT_BAT;
            else if (step_q == STEP_GETID) state_d = S_WAIT_ID;
            else                           advance = 1'b1;
          end else if ((rx_data == RSP_RESEND) && (resend_q < 2'(MAX_RESEND))) begin
            resend_d = resend_q + 2'd1;
            state_d  = S_SEND;
          end else begin
            fail = 1'b1;
          end
        end
      end
      S_WAIT_BAT: begin
        if (rx_err || (timer_q == '0)) fail = 1'b1;
        else if (rx_valid) begin
          accept = 1'b1;
          // 0xFC (self-test failed) and anything else restart the sequence
          if (rx_data == RSP_BAT_OK) state_d = S_WAIT_BAT_ID;
          else                       fail = 1'b1;
        end
      end
      S_WAIT_BAT_ID: begin
        if (rx_err || (timer_q == '0)) fail = 1'b1;
        else if (rx_valid) begin
          accept = 1'b1;
          if (rx_data == RSP_BAT_ID) advance = 1'b1;
          else                       fail = 1'b1;
        end
      end
      S_WAIT_ID: begin
        if (rx_err || (timer_q == '0)) fail = 1'b1;
        else if (rx_valid) begin
          accept = 1'b1;
`ifdef PS2_MOUSE_WHEEL_EN
          wheel_d = (rx_data == ID_WHEEL);
`endif
          advance = 1'b1;
        end
      end
      S_STREAM: ;
      S_ERROR:  ;
      default:  state_d = S_IDLE_RST;
    endcase

    if (advance) begin
      step_d   = step_q + 4'd1;
      resend_d = '0;
      if (step_q == STEP_LAST) begin
        state_d = S_STREAM;
        retry_d = '0;
      end else begin
        state_d = S_SEND;
      end
    end

    if (fail) begin
      step_d   = '0;
      resend_d = '0;
      retry_d  = RTY_W'(retry_inc);
      if (retry_inc < MAX_RETRY) begin
        state_d = S_SEND;
      end else begin
        state_d    = S_ERROR;
        init_err_d = 1'b1;
      end
    end

    // reinit overrides anything else that happened this cycle
    if (reinit) begin
      state_d    = S_SEND;
      step_d     = '0;
      resend_d   = '0;
      retry_d    = '0;
      init_err_d = 1'b0;
      wheel_d    = 1'b0;
      tx_req_d   = 1'b0;
    end

    if ((state_d != state_q) || accept) begin
      timer_d = ((state_d == S_WAIT_BAT) || (state_d == S_WAIT_BAT_ID)) ? BAT_LD : ACK_LD;
    end
  end

  // Init FSM registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE_RST;
      step_q      <= '0;
      resend_q    <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      busy_seen_q <= 1'b0;
      tx_req_q    <= 1'b0;
      tx_data_q   <= '0;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
      wheel_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      resend_q    <= resend_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      busy_seen_q <= busy_seen_d;
      tx_req_q    <= tx_req_d;
      tx_data_q   <= tx_data_d;
      init_done_q <= (state_d == S_STREAM);
      init_err_q  <= init_err_d;
      wheel_q     <= wheel_d;
    end
  end

  assign tx_req     = tx_req_q;
  assign tx_data    = tx_data_q;
  assign init_done  = init_done_q;
  assign init_err   = init_err_q;
  assign wheel_mode = wheel_q;

  ps2_pkt_asm #(
    .GAP_CYC (GAP_CYC)
  ) u_pkt_asm (
    .CLK        (CLK),
    .RST        (RST),
    .en         (state_q == S_STREAM),
    .wheel_mode (wheel_q),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .pkt_valid  (pkt_valid),
    .btn        (btn),
    .dx         (dx),
    .dy         (dy),
    .dz         (dz),
    .ovf        (ovf)
  );

endmodule
